// File: rtl/req_priority_latch_pkg.sv
// Shared types and helpers for the request-capture stage that feeds the 4-to-2 priority encoder.
// Holds the channel/code widths, the presentation FSM states and the drop popcount.
package req_priority_latch_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Number of channels that lost an event in one cycle (0..4).
  function automatic logic [2:0] popcount4(input logic [N_REQ-1:0] bits);
    return {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};
  endfunction

endpackage

// File: rtl/req_priority_latch_prio_enc4.sv
// Combinational 4-to-2 highest-priority encoder; bit 3 wins.
// The any flag is set whenever at least one input bit is set.
module prio_enc4
  import req_priority_latch_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  always_comb begin
    any  = |vec;
    code = 2'd0;
    if (vec[3])      code = 2'd3;
    else if (vec[2]) code = 2'd2;
    else if (vec[1]) code = 2'd1;
    else             code = 2'd0;
  end

endmodule

// File: rtl/req_priority_latch.sv
// Request-capture stage: edge-detects requests into sticky pending bits and presents the
// highest-priority pending code over a valid/ack handshake, counting events lost to pending channels.
module req_priority_latch
  import req_priority_latch_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  input  logic              ack,
  output logic [CODE_W-1:0] y,
  output logic              v,
  output logic [N_REQ-1:0]  pending,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [N_REQ-1:0]  req_q;
  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  drop;
  logic [N_REQ-1:0]  pending_d;
  logic [CODE_W-1:0] enc_code;
  logic              any_pending;
  logic [CODE_W-1:0] y_d;
  logic              v_d;
  logic [CNT_W+2:0]  cnt_sum;
  state_t            state;
  state_t            state_d;

  prio_enc4 u_enc (
    .vec  (pending),
    .code (enc_code),
    .any  (any_pending)
  );

  // A set on the same cycle as the channel's clear keeps the bit and is not a drop.
  always_comb begin
    rise      = req & ~req_q & mask;
    drop      = rise & pending & ~clr;
    pending_d = (pending & ~clr) | rise;
    cnt_sum   = {3'b000, drop_cnt} + {{CNT_W{1'b0}}, popcount4(drop)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      req_q   <= req;
      pending <= pending_d;
      if (cnt_sum > {3'b000, {CNT_W{1'b1}}}) drop_cnt <= '1;
      else                                   drop_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      v     <= 1'b0;
    end else begin
      state <= state_d;
      y     <= y_d;
      v     <= v_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_pending) state_d = PRESENT;
      PRESENT: if (ack)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // No preemption: the code is captured once in IDLE and held until acknowledged.
  always_comb begin
    y_d = y;
    v_d = v;
    clr = '0;
    case (state)
      IDLE: begin
        if (any_pending) begin
          y_d = enc_code;
          v_d = 1'b1;
        end
      end
      PRESENT: begin
        if (ack) begin
          v_d    = 1'b0;
          clr[y] = 1'b1;
        end
      end
      default: v_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_req_priority_latch.sv
// Self-checking bench for req_priority_latch: table of per-cycle vectors through a scoreboard queue,
// plus hand-written reset sequences. A second instance with a 2-bit counter exercises saturation.
module tb_req_priority_latch;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       ev;
    logic [1:0] ey;
    logic [3:0] ep;
    int         ed;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] y;
  logic       v;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic [1:0] y2;
  logic       v2;
  logic [3:0] pending2;
  logic [1:0] drop_cnt2;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  req_priority_latch #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .y        (y),
    .v        (v),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  req_priority_latch #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .y        (y2),
    .v        (v2),
    .pending  (pending2),
    .drop_cnt (drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] r, input logic [3:0] m, input logic a,
                        input logic e_v, input logic [1:0] e_y, input logic [3:0] e_p,
                        input int e_d);
    vec_t t;
    t.req = r; t.mask = m; t.ack = a;
    t.ev = e_v; t.ey = e_y; t.ep = e_p; t.ed = e_d;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    int   ed2;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_underflow step=%0d actual=0 required=1", idx);
      return;
    end
    e   = sb.pop_front();
    ed2 = (e.ed > 3) ? 3 : e.ed;
    cmp($sformatf("v[%0d]", idx), int'(v), int'(e.ev));
    if (e.ev) cmp($sformatf("y[%0d]", idx), int'(y), int'(e.ey));
    cmp($sformatf("pending[%0d]", idx), int'(pending), int'(e.ep));
    cmp($sformatf("drop_cnt[%0d]", idx), int'(drop_cnt), e.ed);
    cmp($sformatf("drop_cnt_w2[%0d]", idx), int'(drop_cnt2), ed2);
  endtask

  task automatic applyStimulus(input vec_t t, input int idx);
    req  = t.req;
    mask = t.mask;
    ack  = t.ack;
    sb.push_back(t);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'hF;
    mask  = 4'hF;
    ack   = 1'b0;

    // reset release with all lines high: pending fills, then code 3 is presented
    addVec(4'hF, 4'hF, 0, 0, 0, 4'hF, 0);
    addVec(4'hF, 4'hF, 0, 1, 3, 4'hF, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h7, 0);
    addVec(4'h0, 4'hF, 1, 1, 2, 4'h7, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h3, 0);
    addVec(4'h0, 4'hF, 1, 1, 1, 4'h3, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h1, 0);
    addVec(4'h0, 4'hF, 1, 1, 0, 4'h1, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h0, 0);
    addVec(4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
    // priority drain of 4'b0101 with ack held high
    addVec(4'h5, 4'hF, 1, 0, 0, 4'h5, 0);
    addVec(4'h0, 4'hF, 1, 1, 2, 4'h5, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h1, 0);
    addVec(4'h0, 4'hF, 1, 1, 0, 4'h1, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h0, 0);
    addVec(4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
    // hold without ack, then a higher-priority request must wait
    addVec(4'h2, 4'hF, 0, 0, 0, 4'h2, 0);
    addVec(4'h0, 4'hF, 0, 1, 1, 4'h2, 0);
    for (int i = 0; i < 9; i++) addVec(4'h0, 4'hF, 0, 1, 1, 4'h2, 0);
    addVec(4'h8, 4'hF, 0, 1, 1, 4'hA, 0);
    addVec(4'h0, 4'hF, 0, 1, 1, 4'hA, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h8, 0);
    addVec(4'h0, 4'hF, 0, 1, 3, 4'h8, 0);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h0, 0);
    addVec(4'h0, 4'hF, 0, 0, 0, 4'h0, 0);
    // drops on channel 0, saturation of the narrow counter, multi-drop cycles
    addVec(4'h1, 4'hF, 0, 0, 0, 4'h1, 0);
    addVec(4'h0, 4'hF, 0, 1, 0, 4'h1, 0);
    addVec(4'h1, 4'hF, 0, 1, 0, 4'h1, 1);
    addVec(4'h0, 4'hF, 0, 1, 0, 4'h1, 1);
    addVec(4'h1, 4'hF, 0, 1, 0, 4'h1, 2);
    addVec(4'h0, 4'hF, 0, 1, 0, 4'h1, 2);
    for (int k = 3; k <= 7; k++) begin
      addVec(4'h1, 4'hF, 0, 1, 0, 4'h1, k);
      addVec(4'h0, 4'hF, 0, 1, 0, 4'h1, k);
    end
    addVec(4'hF, 4'hF, 0, 1, 0, 4'hF, 8);
    addVec(4'h0, 4'hF, 0, 1, 0, 4'hF, 8);
    addVec(4'hF, 4'hF, 0, 1, 0, 4'hF, 12);
    addVec(4'h0, 4'hF, 0, 1, 0, 4'hF, 12);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'hE, 12);
    addVec(4'h0, 4'hF, 1, 1, 3, 4'hE, 12);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h6, 12);
    addVec(4'h0, 4'hF, 1, 1, 2, 4'h6, 12);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h2, 12);
    addVec(4'h0, 4'hF, 1, 1, 1, 4'h2, 12);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h0, 12);
    addVec(4'h0, 4'hF, 0, 0, 0, 4'h0, 12);
    // set/clear collision on channel 2
    addVec(4'h4, 4'hF, 0, 0, 0, 4'h4, 12);
    addVec(4'h0, 4'hF, 0, 1, 2, 4'h4, 12);
    addVec(4'h4, 4'hF, 1, 0, 0, 4'h4, 12);
    addVec(4'h0, 4'hF, 0, 1, 2, 4'h4, 12);
    addVec(4'h0, 4'hF, 1, 0, 0, 4'h0, 12);
    addVec(4'h0, 4'hF, 0, 0, 0, 4'h0, 12);
    // masking: masked edge ignored, mask change does not disturb a presented code
    addVec(4'h1, 4'hE, 0, 0, 0, 4'h0, 12);
    addVec(4'h0, 4'hE, 0, 0, 0, 4'h0, 12);
    addVec(4'h0, 4'hE, 0, 0, 0, 4'h0, 12);
    addVec(4'h4, 4'hE, 0, 0, 0, 4'h4, 12);
    addVec(4'h0, 4'hA, 0, 1, 2, 4'h4, 12);
    addVec(4'h0, 4'hA, 0, 1, 2, 4'h4, 12);
    addVec(4'h0, 4'hA, 1, 0, 0, 4'h0, 12);
    addVec(4'h0, 4'hA, 0, 0, 0, 4'h0, 12);
    // leave code 3 presented for the mid-operation reset
    addVec(4'h8, 4'hF, 0, 0, 0, 4'h8, 12);
    addVec(4'h0, 4'hF, 0, 1, 3, 4'h8, 12);

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_v", int'(v), 0);
    cmp("reset_y", int'(y), 0);
    cmp("reset_pending", int'(pending), 0);
    cmp("reset_drop_cnt", int'(drop_cnt), 0);
    cmp("reset_v_w2", int'(v2), 0);
    cmp("reset_drop_cnt_w2", int'(drop_cnt2), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    rst_n = 1'b0;
    #2;
    cmp("midreset_v", int'(v), 0);
    cmp("midreset_y", int'(y), 0);
    cmp("midreset_pending", int'(pending), 0);
    cmp("midreset_drop_cnt", int'(drop_cnt), 0);
    cmp("midreset_v_w2", int'(v2), 0);
    cmp("midreset_y_w2", int'(y2), 0);
    cmp("midreset_pending_w2", int'(pending2), 0);
    cmp("midreset_drop_cnt_w2", int'(drop_cnt2), 0);
    cmp("sb_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
